// File: rtl/ota_cmp_decimator_if.sv
// Bundle of the decimator's control inputs and result outputs.
// The master drives the controls and the slave (the decimator) returns results.
interface ota_cmp_decimator_if;
    logic       ena;
    logic       cmp_async;
    logic       run;
    logic [1:0] win_sel;
    logic [7:0] density;
    logic [7:0] toggles;
    logic       valid;
    logic       busy;

    modport master (
        output ena, cmp_async, run, win_sel,
        input  density, toggles, valid, busy
    );

    modport slave (
        input  ena, cmp_async, run, win_sel,
        output density, toggles, valid, busy
    );
endinterface

// File: rtl/ota_cmp_decimator.sv
// Synchronizes the OTA comparator output and reduces each window of samples to a
// saturated ones-density code and a transition count, with a one-cycle valid strobe.
module ota_cmp_decimator #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    ota_cmp_decimator_if.slave bus
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StAcc  = 1'b1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    logic [0:0] state_q, state_d;
    logic [1:0] len_q, len_d;
    logic [8:0] ones_q, ones_d;
    logic [8:0] tog_q, tog_d;
    logic [7:0] idx_q, idx_d;
    logic       prev_q, prev_d;
    logic [7:0] density_q, density_d;
    logic [7:0] toggles_q, toggles_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;

    logic [8:0]  ones_fin;
    logic [8:0]  tog_fin;
    logic [11:0] dens_wide;
    logic [7:0]  last_idx;
    logic        win_end;

    assign s = sync_q[SYNC_STAGES-1];

    // The synchronizer ignores ena so the sampled level is always fresh.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.cmp_async};
        end
    end

    always_comb begin
        case (len_q)
            2'd0:    last_idx = 8'd31;
            2'd1:    last_idx = 8'd63;
            2'd2:    last_idx = 8'd127;
            default: last_idx = 8'd255;
        endcase
    end

    // Final counts include the sample taken on the closing edge.
    assign ones_fin  = ones_q + {8'd0, s};
    assign tog_fin   = tog_q + {8'd0, s ^ prev_q};
    assign dens_wide = {3'd0, ones_fin} << (2'd3 - len_q);
    assign win_end   = (state_q == StAcc) && bus.ena && (idx_q == last_idx);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        ones_d    = ones_q;
        tog_d     = tog_q;
        idx_d     = idx_q;
        prev_d    = prev_q;
        density_d = density_q;
        toggles_d = toggles_q;
        valid_d   = 1'b0;

        if (bus.ena) begin
            prev_d = s;
            case (state_q)
                StIdle: begin
                    if (bus.run) begin
                        state_d = StAcc;
                        len_d   = bus.win_sel;
                    end
                end
                StAcc: begin
                    if (win_end) begin
                        density_d = (dens_wide > 12'd255) ? 8'hff : dens_wide[7:0];
                        toggles_d = tog_fin[8] ? 8'hff : tog_fin[7:0];
                        valid_d   = 1'b1;
                        ones_d    = '0;
                        tog_d     = '0;
                        idx_d     = '0;
                        if (bus.run) begin
                            len_d = bus.win_sel;
                        end else begin
                            state_d = StIdle;
                        end
                    end else if (!bus.run) begin
                        state_d = StIdle;
                        ones_d  = '0;
                        tog_d   = '0;
                        idx_d   = '0;
                    end else begin
                        ones_d = ones_fin;
                        tog_d  = tog_fin;
                        idx_d  = idx_q + 8'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d == StAcc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            len_q     <= 2'd0;
            ones_q    <= '0;
            tog_q     <= '0;
            idx_q     <= '0;
            prev_q    <= 1'b0;
            density_q <= '0;
            toggles_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            ones_q    <= ones_d;
            tog_q     <= tog_d;
            idx_q     <= idx_d;
            prev_q    <= prev_d;
            density_q <= density_d;
            toggles_q <= toggles_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.density = density_q;
    assign bus.toggles = toggles_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_ota_cmp_decimator.sv
// Bench for ota_cmp_decimator: directed scenarios plus a randomized run, all
// checked against a window-level reference model that works on recorded samples.
module tb_ota_cmp_decimator;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ota_cmp_decimator_if bus ();

    ota_cmp_decimator #(.SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: samples of the current window are kept in a queue and
    // reduced with plain arithmetic when the window fills.
    bit m_pipe[$];
    bit m_samples[$];
    bit m_prev;
    bit m_first_prev;
    bit m_in_acc;
    bit m_valid;
    int m_len;
    int m_density;
    int m_toggles;

    task automatic model_edge();
        bit s;
        int ones;
        int t;
        m_valid = 1'b0;
        if (!rst_n) begin
            m_pipe = {};
            repeat (SYNC) m_pipe.push_back(1'b0);
            m_samples = {};
            m_prev    = 1'b0;
            m_in_acc  = 1'b0;
            m_density = 0;
            m_toggles = 0;
        end else begin
            s = m_pipe.pop_front();
            m_pipe.push_back(bus.cmp_async);
            if (bus.ena) begin
                if (!m_in_acc) begin
                    if (bus.run) begin
                        m_in_acc = 1'b1;
                        m_len    = 32 << bus.win_sel;
                    end
                end else begin
                    if (m_samples.size() == 0) m_first_prev = m_prev;
                    m_samples.push_back(s);
                    if (m_samples.size() == m_len) begin
                        ones = 0;
                        t    = 0;
                        foreach (m_samples[i]) begin
                            ones += int'(m_samples[i]);
                            if (i == 0) t += int'(m_samples[i] != m_first_prev);
                            else        t += int'(m_samples[i] != m_samples[i-1]);
                        end
                        m_density = ones * 256 / m_len;
                        if (m_density > 255) m_density = 255;
                        m_toggles = (t > 255) ? 255 : t;
                        m_valid   = 1'b1;
                        m_samples = {};
                        if (bus.run) m_len = 32 << bus.win_sel;
                        else         m_in_acc = 1'b0;
                    end else if (!bus.run) begin
                        m_in_acc  = 1'b0;
                        m_samples = {};
                    end
                end
                m_prev = s;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.run = 1'b1;
        bus.cmp_async = 1'b1;
        repeat (3) step();
        checks++; if (bus.valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %0b expected 0", bus.valid); end
        checks++; if (bus.density !== 8'd0) begin errors++;
            $display("FAIL reset_density: got %0d expected 0", bus.density); end
        checks++; if (bus.toggles !== 8'd0) begin errors++;
            $display("FAIL reset_toggles: got %0d expected 0", bus.toggles); end
        checks++; if (bus.busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        rst_n = 1'b1;
        bus.run = 1'b0;
        step();
    endtask

    task automatic test_const_high();
        int t;
        bit got;
        bus.cmp_async = 1'b1;
        bus.win_sel = 2'd3;
        repeat (6) step();
        bus.run = 1'b1;
        t = 0; got = 1'b0;
        while (!got && t < 300) begin
            step(); t++;
            if (t == 50) begin
                checks++; if (bus.busy !== 1'b1) begin errors++;
                    $display("FAIL high_busy: got %0b expected 1", bus.busy); end
            end
            if (bus.valid === 1'b1) got = 1'b1;
        end
        checks++; if (!got || t - 1 != 256) begin errors++;
            $display("FAIL high_latency: got %0d expected 256 (seen=%0b)", t - 1, got); end
        checks++; if (bus.density !== 8'd255) begin errors++;
            $display("FAIL high_density: got %0d expected 255", bus.density); end
        checks++; if (bus.toggles !== 8'd0) begin errors++;
            $display("FAIL high_toggles: got %0d expected 0", bus.toggles); end
        step();
        checks++; if (bus.valid !== 1'b0) begin errors++;
            $display("FAIL high_valid_width: got %0b expected 0", bus.valid); end
        bus.run = 1'b0;
        repeat (4) step();
        checks++; if (bus.busy !== 1'b0) begin errors++;
            $display("FAIL high_busy_fall: got %0b expected 0", bus.busy); end
    endtask

    task automatic test_alternating();
        int t, last, nv;
        bus.win_sel = 2'd0;
        for (int i = 0; i < 10; i++) begin bus.cmp_async = ~bus.cmp_async; step(); end
        bus.run = 1'b1;
        t = 0; last = 1; nv = 0;
        while (nv < 3 && t < 200) begin
            bus.cmp_async = ~bus.cmp_async;
            step(); t++;
            if (bus.valid === 1'b1) begin
                checks++; if (t - last != 32) begin errors++;
                    $display("FAIL alt_period: got %0d expected 32", t - last); end
                checks++; if (bus.density !== 8'd128) begin errors++;
                    $display("FAIL alt_density: got %0d expected 128", bus.density); end
                checks++; if (bus.toggles !== 8'd32) begin errors++;
                    $display("FAIL alt_toggles: got %0d expected 32", bus.toggles); end
                last = t; nv++;
            end
        end
        checks++; if (nv != 3) begin errors++;
            $display("FAIL alt_count: got %0d expected 3", nv); end
        bus.run = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_quarter();
        int t, last, nv, ph;
        int exp_per[2];
        int exp_tog[2];
        exp_per[0] = 64; exp_per[1] = 128;
        exp_tog[0] = 32; exp_tog[1] = 64;
        ph = 0;
        bus.win_sel = 2'd1;
        repeat (8) begin bus.cmp_async = (ph % 4 == 0); ph++; step(); end
        bus.run = 1'b1;
        t = 0; last = 1; nv = 0;
        while (nv < 2 && t < 400) begin
            bus.cmp_async = (ph % 4 == 0); ph++;
            if (t == 20) bus.win_sel = 2'd2;
            step(); t++;
            if (bus.valid === 1'b1) begin
                checks++; if (t - last != exp_per[nv]) begin errors++;
                    $display("FAIL quarter_period: got %0d expected %0d", t - last, exp_per[nv]); end
                checks++; if (bus.density !== 8'd64) begin errors++;
                    $display("FAIL quarter_density: got %0d expected 64", bus.density); end
                checks++; if (int'(bus.toggles) != exp_tog[nv]) begin errors++;
                    $display("FAIL quarter_toggles: got %0d expected %0d", bus.toggles, exp_tog[nv]); end
                last = t; nv++;
            end
        end
        checks++; if (nv != 2) begin errors++;
            $display("FAIL quarter_count: got %0d expected 2", nv); end
        bus.run = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_abort();
        int t, nv, exp_d, exp_t;
        bit got;
        bus.win_sel = 2'd0;
        bus.run = 1'b1;
        t = 0; got = 1'b0;
        while (!got && t < 40) begin
            bus.cmp_async = 1'($urandom_range(0, 1));
            step(); t++;
            if (bus.valid === 1'b1) got = 1'b1;
        end
        checks++; if (!got) begin errors++;
            $display("FAIL abort_first_window: got no valid expected valid"); end
        checks++; if (int'(bus.density) != m_density) begin errors++;
            $display("FAIL abort_first_density: got %0d expected %0d", bus.density, m_density); end
        checks++; if (int'(bus.toggles) != m_toggles) begin errors++;
            $display("FAIL abort_first_toggles: got %0d expected %0d", bus.toggles, m_toggles); end
        exp_d = m_density;
        exp_t = m_toggles;
        nv = 0;
        repeat (10) begin bus.cmp_async = 1'($urandom_range(0, 1)); step();
            if (bus.valid === 1'b1) nv++; end
        bus.run = 1'b0;
        repeat (6) begin bus.cmp_async = 1'($urandom_range(0, 1)); step();
            if (bus.valid === 1'b1) nv++; end
        checks++; if (nv != 0) begin errors++;
            $display("FAIL abort_valid: got %0d pulses expected 0", nv); end
        checks++; if (int'(bus.density) != exp_d) begin errors++;
            $display("FAIL abort_density_hold: got %0d expected %0d", bus.density, exp_d); end
        checks++; if (int'(bus.toggles) != exp_t) begin errors++;
            $display("FAIL abort_toggles_hold: got %0d expected %0d", bus.toggles, exp_t); end
        checks++; if (bus.busy !== 1'b0) begin errors++;
            $display("FAIL abort_busy: got %0b expected 0", bus.busy); end
        bus.run = 1'b1;
        repeat (11) begin bus.cmp_async = 1'($urandom_range(0, 1)); step(); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.run = 1'b0;
        checks++; if (bus.density !== 8'd0 || bus.toggles !== 8'd0) begin errors++;
            $display("FAIL midreset_outputs: got %0d/%0d expected 0/0", bus.density, bus.toggles); end
        checks++; if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL midreset_flags: got valid=%0b busy=%0b expected 0/0", bus.valid, bus.busy); end
        repeat (3) step();
    endtask

    task automatic test_ena_gating();
        int i;
        bit got;
        bus.cmp_async = 1'b1;
        bus.win_sel = 2'd0;
        repeat (6) step();
        bus.run = 1'b1;
        i = 0; got = 1'b0;
        while (!got && i < 60) begin
            bus.ena = (i >= 10 && i < 15) ? 1'b0 : 1'b1;
            step();
            if (bus.valid === 1'b1) got = 1'b1;
            else i++;
        end
        bus.ena = 1'b1;
        checks++; if (!got || i != 37) begin errors++;
            $display("FAIL ena_latency: got %0d expected 37 (seen=%0b)", i, got); end
        checks++; if (bus.density !== 8'd255) begin errors++;
            $display("FAIL ena_density: got %0d expected 255", bus.density); end
        bus.run = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_const_low();
        int t;
        bit got;
        bus.cmp_async = 1'b0;
        bus.win_sel = 2'd0;
        repeat (6) step();
        bus.run = 1'b1;
        t = 0; got = 1'b0;
        while (!got && t < 40) begin
            step(); t++;
            if (bus.valid === 1'b1) got = 1'b1;
        end
        checks++; if (!got || t - 1 != 32) begin errors++;
            $display("FAIL low_latency: got %0d expected 32 (seen=%0b)", t - 1, got); end
        checks++; if (bus.density !== 8'd0) begin errors++;
            $display("FAIL low_density: got %0d expected 0", bus.density); end
        checks++; if (bus.toggles !== 8'd0) begin errors++;
            $display("FAIL low_toggles: got %0d expected 0", bus.toggles); end
        bus.run = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            bus.ena = ($urandom_range(0, 7) != 0);
            bus.run = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 39) == 0) bus.win_sel = 2'($urandom_range(0, 3) & $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) bus.cmp_async = 1'($urandom_range(0, 1));
            step();
            checks++; if (bus.valid !== m_valid) begin errors++;
                $display("FAIL rand_valid@%0d: got %0b expected %0b", c, bus.valid, m_valid); end
            checks++; if (int'(bus.density) != m_density) begin errors++;
                $display("FAIL rand_density@%0d: got %0d expected %0d", c, bus.density, m_density); end
            checks++; if (int'(bus.toggles) != m_toggles) begin errors++;
                $display("FAIL rand_toggles@%0d: got %0d expected %0d", c, bus.toggles, m_toggles); end
        end
        rst_n = 1'b1;
        bus.ena = 1'b1;
        bus.run = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ena = 1'b1;
        bus.cmp_async = 1'b0;
        bus.run = 1'b0;
        bus.win_sel = 2'd0;
        m_pipe = {};
        repeat (SYNC) m_pipe.push_back(1'b0);
        test_reset();
        test_const_high();
        test_alternating();
        test_quarter();
        test_abort();
        test_ena_gating();
        test_const_low();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
